mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_BITS, default 9: word-address width; the memory depth SHALL be 2**ADDR_BITS 32-bit words.
REQ-002 Parameter LATENCY, default 2: wait cycles from request acceptance to access; legal range 1..15.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge, except on clr.
REQ-004 clr  input  1  asynchronous, active-high reset.
REQ-005 read  input  1  read request, level; the initiator holds it until done.
REQ-006 write  input  1  write request, level; the initiator holds it until done.
REQ-007 address  input  ADDR_BITS  word address, sampled at acceptance.
REQ-008 data_in  input  32  write data, sampled at acceptance.
REQ-009 data_out  output  32  registered read data.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 error  output  1  one-cycle pulse on an illegal request (read and write both high).

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, RESPOND, ERR and DRAIN; done, busy and error SHALL be Moore outputs.
REQ-014 IDLE, exactly one of read/write high at an edge (the accepting edge, edge 0): latch address, data_in and direction, load the counter with LATENCY-1, go to WAIT.
REQ-015 IDLE, read and write both high: go to ERR, latch nothing, perform no memory access.
REQ-016 WAIT, counter nonzero: decrement the counter and stay in WAIT.
REQ-017 WAIT, counter zero: perform the access with the latched values and go to RESPOND, so done is high in the cycle after edge LATENCY.
REQ-018 Read access: data_out SHALL take mem[latched address] at the WAIT->RESPOND edge.
REQ-019 Write access: mem[latched address] SHALL take the latched data at that same edge, and data_out SHALL be unchanged.
REQ-020 data_out SHALL hold its last read value until the next read completes.
REQ-021 RESPOND: done=1 for exactly one cycle, then go unconditionally to DRAIN.
REQ-022 ERR: error=1 for exactly one cycle, then go unconditionally to DRAIN.
REQ-023 DRAIN: go to IDLE only when read=0 and write=0; a request held high SHALL never cause a second access.
REQ-024 Changes on address, data_in, read or write after edge 0 and before DRAIN SHALL NOT affect the transaction in progress.
REQ-025 The address SHALL cover the full range 0..2**ADDR_BITS-1 with no wrap, aliasing or bounds fault.
REQ-026 The counter SHALL be 4 bits wide and SHALL NOT underflow.

Reset
REQ-027 clr high SHALL immediately force state IDLE, counter 0, data_out 0x00000000, done 0, busy 0, error 0, and clear all latched values.
REQ-028 clr asserted mid-transaction SHALL abort it with no memory write and no done pulse.
REQ-029 clr SHALL NOT clear the memory array; the array SHALL be zero-initialised at time zero for simulation.
REQ-030 After clr deasserts, a request already high SHALL be accepted at the next edge as a new transaction.

Verification
REQ-031 Reset check: assert clr mid-cycle -> all outputs 0 asynchronously, before the next clk edge.
REQ-032 Write then read, LATENCY=2:
- write 0xDEADBEEF to address 0x005 -> done high in the cycle after edge 2; busy high from edge 0 until requests drop in DRAIN.
- then read address 0x005 -> data_out = 0xDEADBEEF when done is high.
REQ-033 Held request: keep read high for 6 cycles after done -> exactly one done pulse, busy stays 1 until read drops, then IDLE the next edge.
REQ-034 Illegal request: read=write=1 with address 0x005, data_in 0x12345678 -> error pulse for one cycle, no done; a later read of 0x005 returns 0xDEADBEEF.
REQ-035 Latching and top address:
- write 0xA5A5A5A5 to 0x1FF; during WAIT change address to 0x000 and data_in to 0 -> 0x1FF holds 0xA5A5A5A5 and 0x000 is unchanged.
- LATENCY=1 -> done in the cycle after edge 1.
REQ-036 Reset abort: clr pulse during WAIT of a write of 0x0BADF00D to 0x010 -> no done pulse; a later read of 0x010 returns its prior value, 0x00000000.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: single-port 32-bit memory behind a level-request handshake
// with a fixed access latency, one-cycle done/error pulses and a drain phase.
module mem_responder #(
   parameter int ADDR_BITS = 9,
   parameter int LATENCY   = 2
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 read,
   input  logic                 write,
   input  logic [ADDR_BITS-1:0] address,
   input  logic [31:0]          data_in,
   output logic [31:0]          data_out,
   output logic                 done,
   output logic                 busy,
   output logic                 error
);
   typedef enum logic [2:0] {IDLE, WAIT, RESPOND, ERR, DRAIN} state_t;
   localparam logic [3:0] LOAD = 4'(LATENCY - 1);
   state_t                 r_state, w_next;
   logic [3:0]             r_cnt;
   logic [ADDR_BITS-1:0]   r_addr;
   logic [31:0]            r_data;
   logic                   r_wr;
   logic [31:0]            r_mem [2**ADDR_BITS] = '{default: '0};
   logic                   w_access;
   assign w_access = (r_state == WAIT) && (r_cnt == 4'd0);
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = (read && write) ? ERR : (read || write) ? WAIT : IDLE;
         WAIT:    w_next = (r_cnt == 4'd0) ? RESPOND : WAIT;
         RESPOND: w_next = DRAIN;
         ERR:     w_next = DRAIN;
         DRAIN:   w_next = (!read && !write) ? IDLE : DRAIN;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state  <= IDLE;
         r_cnt    <= 4'd0;
         r_addr   <= '0;
         r_data   <= '0;
         r_wr     <= 1'b0;
         data_out <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && (read ^ write)) begin
            r_addr <= address;
            r_data <= data_in;
            r_wr   <= write;
            r_cnt  <= LOAD;
         end else if (r_state == WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_access && !r_wr) data_out <= r_mem[r_addr];
      end
   end
   // The array is deliberately outside the clr domain so reset never erases contents.
   always_ff @(posedge clk) begin
      if (w_access && r_wr) r_mem[r_addr] <= r_data;
   end
   assign done  = (r_state == RESPOND);
   assign error = (r_state == ERR);
   assign busy  = (r_state != IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized transactions on LATENCY=2 and LATENCY=1 responders
// sharing one stimulus, checked against an array model of the memory.
module tb_mem_responder;
   logic        clk = 1'b0;
   logic        clr, read, write;
   logic [8:0]  address;
   logic [31:0] data_in;
   logic [31:0] do2, do1;
   logic        dn2, bs2, er2, dn1, bs1, er1;
   logic [31:0] mdl [512];
   logic [31:0] last2, last1;
   int          n_chk = 0;
   int          n_bad = 0;
   always #5 clk = ~clk;
   mem_responder #(.ADDR_BITS(9), .LATENCY(2)) u_dut2 (
      .clk(clk), .clr(clr), .read(read), .write(write), .address(address),
      .data_in(data_in), .data_out(do2), .done(dn2), .busy(bs2), .error(er2));
   mem_responder #(.ADDR_BITS(9), .LATENCY(1)) u_dut1 (
      .clk(clk), .clr(clr), .read(read), .write(write), .address(address),
      .data_in(data_in), .data_out(do1), .done(dn1), .busy(bs1), .error(er1));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic chk_idle(input string tag);
      chk({tag, "_bs2"}, 32'(bs2), 0);
      chk({tag, "_bs1"}, 32'(bs1), 0);
      chk({tag, "_dn2"}, 32'(dn2), 0);
      chk({tag, "_dn1"}, 32'(dn1), 0);
      chk({tag, "_er2"}, 32'(er2), 0);
      chk({tag, "_er1"}, 32'(er1), 0);
   endtask
   // abort: 0 none, 1 clr during WAIT then drop request, 2 clr during WAIT with request held
   task automatic txn(input logic rd, input logic wr, input logic [8:0] a,
                      input logic [31:0] d, input int hold, input int abort);
      logic legal = rd ^ wr;
      logic [31:0] rdv;
      @(negedge clk);
      read = rd; write = wr; address = a; data_in = d;
      if (abort != 0) begin
         @(posedge clk);
         #2 clr = 1'b1;
         #1;
         last1 = 0; last2 = 0;
         chk_idle("abort");
         chk("abort_do2", do2, 0);
         chk("abort_do1", do1, 0);
         @(negedge clk);
         clr = 1'b0;
         address = a; data_in = d;
         if (abort == 1) begin
            read = 1'b0; write = 1'b0;
            @(posedge clk);
            #1 chk_idle("abort_after");
            return;
         end
      end
      rdv = mdl[a];
      @(posedge clk);
      for (int k = 0; k <= 3 + hold; k++) begin
         if (k > 0) @(posedge clk);
         #1;
         chk("done2", 32'(dn2), 32'(legal && k == 2));
         chk("done1", 32'(dn1), 32'(legal && k == 1));
         chk("err2", 32'(er2), 32'(!legal && k == 0));
         chk("err1", 32'(er1), 32'(!legal && k == 0));
         chk("busy2", 32'(bs2), 1);
         chk("busy1", 32'(bs1), 1);
         chk("dout2", do2, (legal && rd && k >= 2) ? rdv : last2);
         chk("dout1", do1, (legal && rd && k >= 1) ? rdv : last1);
         address = 9'($urandom);
         data_in = $urandom;
      end
      if (legal && wr) mdl[a] = d;
      if (legal && rd) begin
         last1 = rdv; last2 = rdv;
      end
      @(negedge clk);
      read = 1'b0; write = 1'b0;
      @(posedge clk);
      #1 chk_idle("drained");
   endtask
   initial begin
      for (int i = 0; i < 512; i++) mdl[i] = 0;
      last1 = 0; last2 = 0;
      clr = 1'b1; read = 1'b0; write = 1'b0; address = '0; data_in = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_idle("reset");
      chk("reset_do2", do2, 0);
      chk("reset_do1", do1, 0);
      @(negedge clk);
      clr = 1'b0;
      txn(0, 1, 9'h005, 32'hDEADBEEF, 0, 0);
      txn(1, 0, 9'h005, 32'h0, 0, 0);
      txn(1, 0, 9'h005, 32'h0, 6, 0);
      txn(1, 1, 9'h005, 32'h12345678, 0, 0);
      txn(1, 0, 9'h005, 32'h0, 0, 0);
      txn(0, 1, 9'h1FF, 32'hA5A5A5A5, 0, 0);
      txn(1, 0, 9'h1FF, 32'h0, 0, 0);
      txn(1, 0, 9'h000, 32'h0, 0, 0);
      txn(0, 1, 9'h010, 32'h0BADF00D, 0, 1);
      txn(1, 0, 9'h010, 32'h0, 0, 0);
      txn(1, 0, 9'h005, 32'h0, 0, 1);
      txn(1, 0, 9'h005, 32'h0, 1, 2);
      txn(0, 1, 9'h011, 32'hCAFEF00D, 0, 2);
      txn(1, 0, 9'h011, 32'h0, 0, 0);
      for (int n = 0; n < 60; n++) begin
         logic [1:0] op = 2'($urandom_range(1, 3));
         logic [8:0] a = (n % 4 == 0) ? 9'($urandom_range(0, 7)) : 9'($urandom);
         txn(op[0], op[1], a, $urandom, int'($urandom_range(0, 3)),
             ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0);
      end
      for (int i = 0; i < 8; i++) txn(1, 0, 9'(i), 32'h0, 0, 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
